// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data memory / IO bus arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_NUM_M   = 2;
    localparam int MEM_ARB_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mem_arb_state_e;

    function automatic logic [MEM_ARB_NUM_M-1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the arbiter, one-hot result, zero when nobody requests.
// MEM_ARB_RR_EN selects round-robin tie breaking; otherwise master 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [MEM_ARB_NUM_M-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic                     last_owner,
`endif
    output logic [MEM_ARB_NUM_M-1:0] win
);

    always_comb begin
        win = '0;
`ifdef MEM_ARB_RR_EN
        // On a tie the master that was not served last goes first.
        if (&req) begin
            win = last_owner ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
`else
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master/one-slave memory arbiter, one transaction in flight; grant is combinational in IDLE,
// response passes through combinationally; slave backpressure holds s_req_o; MEM_ARB_RR_EN = round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT
)(
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [MEM_ARB_NUM_M-1:0]                    m_req_i,
    input  logic [MEM_ARB_NUM_M-1:0]                    m_we_i,
    input  logic [MEM_ARB_NUM_M-1:0][ADDR_W-1:0]        m_addr_i,
    input  logic [MEM_ARB_NUM_M-1:0][DATA_W-1:0]        m_wdata_i,
    input  logic [MEM_ARB_NUM_M-1:0][DATA_W/8-1:0]      m_be_i,
    output logic [MEM_ARB_NUM_M-1:0]                    m_gnt_o,
    output logic [MEM_ARB_NUM_M-1:0]                    m_rvalid_o,
    output logic [DATA_W-1:0]                           m_rdata_o,
    output logic                                        m_err_o,
    output logic                                        s_req_o,
    output logic                                        s_we_o,
    output logic [ADDR_W-1:0]                           s_addr_o,
    output logic [DATA_W-1:0]                           s_wdata_o,
    output logic [DATA_W/8-1:0]                         s_be_o,
    input  logic                                        s_gnt_i,
    input  logic                                        s_rvalid_i,
    input  logic [DATA_W-1:0]                           s_rdata_i,
    output logic                                        busy_o
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    mem_arb_state_e             state;
    logic                       owner;
    logic [CNT_W-1:0]           cnt;
    logic [MEM_ARB_NUM_M-1:0]   win;
    logic                       timeout;
    logic                       rsp_ok;
    logic                       rsp_err;
    logic                       rsp_any;
`ifdef MEM_ARB_RR_EN
    logic                       last_owner;
`endif

    mem_arb_pick u_pick (
        .req        (m_req_i),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .win        (win)
    );

    assign timeout = (cnt == CNT_MAX);
    assign rsp_ok  = (state == WAIT) && s_rvalid_i;
    // A real response beats a simultaneous timeout.
    assign rsp_err = ((state == ISSUE) || (state == WAIT)) && timeout && !rsp_ok;
    assign rsp_any = rsp_ok || rsp_err;

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        if (!rst_i && (state == IDLE)) begin
            m_gnt_o = win;
        end
        if (rsp_any) begin
            m_rvalid_o = owner_onehot(owner);
            m_err_o    = rsp_err;
        end
        if (rsp_ok) begin
            m_rdata_o = s_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            s_be_o     <= '0;
            busy_o     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|win) begin
                        // win is one-hot, so its upper bit is the winner index.
                        owner      <= win[1];
                        s_we_o     <= m_we_i[win[1]];
                        s_addr_o   <= m_addr_i[win[1]];
                        s_wdata_o  <= m_wdata_i[win[1]];
                        s_be_o     <= m_be_i[win[1]];
                        cnt        <= '0;
                        s_req_o    <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ISSUE;
`ifdef MEM_ARB_RR_EN
                        last_owner <= win[1];
`endif
                    end
                end
                ISSUE: begin
                    if (!timeout) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (timeout) begin
                        s_req_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (s_gnt_i) begin
                        s_req_o <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!timeout) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (rsp_any) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    s_req_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 8;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic [1:0]             m_req_i = '0;
    logic [1:0]             m_we_i = '0;
    logic [1:0][AW-1:0]     m_addr_i = '0;
    logic [1:0][DW-1:0]     m_wdata_i = '0;
    logic [1:0][BW-1:0]     m_be_i = '0;
    logic [1:0]             m_gnt_o;
    logic [1:0]             m_rvalid_o;
    logic [DW-1:0]          m_rdata_o;
    logic                   m_err_o;
    logic                   s_req_o;
    logic                   s_we_o;
    logic [AW-1:0]          s_addr_o;
    logic [DW-1:0]          s_wdata_o;
    logic [BW-1:0]          s_be_o;
    logic                   s_gnt_i = 1'b0;
    logic                   s_rvalid_i = 1'b0;
    logic [DW-1:0]          s_rdata_i = '0;
    logic                   busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: is a transaction open, who owns it, has the slave taken it,
    // and how many cycles it has spent since its grant edge.
    logic                   mb_busy = 1'b0;
    int                     mb_owner = 0;
    logic                   mb_acc = 1'b0;
    int                     mb_wait = 0;
    int                     mb_last = 1;
    logic                   f_we;
    logic [AW-1:0]          f_addr;
    logic [DW-1:0]          f_wdata;
    logic [BW-1:0]          f_be;
    logic [1:0]             gnt_last = '0;
    logic [1:0]             e_gnt;
    logic [1:0]             e_rv;
    logic                   e_err;
    logic [DW-1:0]          e_rd;
    logic [1:0]             exp_tie [4];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_be_i     (m_be_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_be_o     (s_be_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model step: expected outputs come from the current inputs and open transaction,
    // then the model advances to what the next clock edge must produce.
    always @(negedge clk) begin
        if (rst_i) begin
            mb_busy  = 1'b0;
            mb_acc   = 1'b0;
            mb_wait  = 0;
            mb_last  = 1;
            gnt_last = '0;
            chk("rst_gnt", m_gnt_o, 0);
            chk("rst_rvalid", m_rvalid_o, 0);
            chk("rst_err", m_err_o, 0);
            chk("rst_sreq", s_req_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_saddr", s_addr_o, 0);
        end else begin
            e_gnt = '0;
            e_rv  = '0;
            e_err = 1'b0;
            e_rd  = '0;
            if (!mb_busy) begin
                if (m_req_i == 2'b11) begin
`ifdef MEM_ARB_RR_EN
                    e_gnt = (mb_last == 1) ? 2'b01 : 2'b10;
`else
                    e_gnt = 2'b01;
`endif
                end else begin
                    e_gnt = m_req_i;
                end
            end else if (mb_acc && s_rvalid_i) begin
                e_rv = 2'b01 << mb_owner;
                e_rd = s_rdata_i;
            end else if (mb_wait == T) begin
                e_rv  = 2'b01 << mb_owner;
                e_err = 1'b1;
            end

            chk("gnt", m_gnt_o, e_gnt);
            chk("rvalid", m_rvalid_o, e_rv);
            chk("err", m_err_o & (|e_rv), e_err);
            if (e_rv != 2'b00) chk("rdata", m_rdata_o, e_rd);
            chk("busy", busy_o, mb_busy);
            chk("sreq", s_req_o, mb_busy && !mb_acc);
            if (mb_busy && !mb_acc) begin
                chk("swe", s_we_o, f_we);
                chk("saddr", s_addr_o, f_addr);
                chk("swdata", s_wdata_o, f_wdata);
                chk("sbe", s_be_o, f_be);
            end

            gnt_last = e_gnt;
            if (e_gnt != 2'b00) begin
                mb_owner = e_gnt[1] ? 1 : 0;
                mb_last  = mb_owner;
                mb_busy  = 1'b1;
                mb_acc   = 1'b0;
                mb_wait  = 0;
                f_we     = m_we_i[mb_owner];
                f_addr   = m_addr_i[mb_owner];
                f_wdata  = m_wdata_i[mb_owner];
                f_be     = m_be_i[mb_owner];
            end else if (mb_busy) begin
                if (e_rv != 2'b00) begin
                    mb_busy = 1'b0;
                end else begin
                    if (!mb_acc && s_gnt_i) mb_acc = 1'b1;
                    mb_wait++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_fields(input int k);
        m_we_i[k]    = 1'($urandom_range(1));
        m_addr_i[k]  = $urandom;
        m_wdata_i[k] = $urandom;
        m_be_i[k]    = 4'($urandom_range(15));
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b10; exp_tie[2] = 2'b01; exp_tie[3] = 2'b10;
`else
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b01; exp_tie[2] = 2'b01; exp_tie[3] = 2'b01;
`endif
        repeat (2) cyc();
        rst_i = 1'b0;

        // Single read by m0.
        cyc(); m_req_i = 2'b01; m_we_i = 2'b00; m_addr_i[0] = 32'h1000; m_be_i[0] = 4'hF;
        #2; chk("rd_gnt", m_gnt_o, 2'b01);
        cyc(); m_req_i = 2'b00; s_gnt_i = 1'b1;
        #2; chk("rd_sreq", s_req_o, 1); chk("rd_saddr", s_addr_o, 32'h1000); chk("rd_swe", s_we_o, 0);
        cyc(); s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
        #2; chk("rd_rvalid", m_rvalid_o, 2'b01); chk("rd_rdata", m_rdata_o, 32'hDEADBEEF);
        chk("rd_err", m_err_o, 0);
        cyc(); s_rvalid_i = 1'b0;
        #2; chk("rd_idle", busy_o, 0);

        // Write by m1.
        cyc(); m_req_i = 2'b10; m_we_i = 2'b10; m_addr_i[1] = 32'h7000; m_wdata_i[1] = 32'hA5;
        m_be_i[1] = 4'b0001;
        #2; chk("wr_gnt", m_gnt_o, 2'b10);
        cyc(); m_req_i = 2'b00; s_gnt_i = 1'b1;
        #2; chk("wr_swe", s_we_o, 1); chk("wr_sbe", s_be_o, 4'b0001);
        chk("wr_swdata", s_wdata_o, 32'hA5); chk("wr_saddr", s_addr_o, 32'h7000);
        cyc(); s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
        #2; chk("wr_rvalid", m_rvalid_o, 2'b10); chk("wr_err", m_err_o, 0);
        cyc(); s_rvalid_i = 1'b0; m_we_i = 2'b00;

        // Slave backpressure with m1 waiting behind.
        cyc(); m_req_i = 2'b01; m_addr_i[0] = 32'h2000; m_wdata_i[0] = 32'h1111;
        #2; chk("bp_gnt", m_gnt_o, 2'b01);
        cyc(); m_req_i = 2'b10; m_addr_i[0] = 32'hFFFF_0000; m_addr_i[1] = 32'h2400;
        for (int c = 0; c < 6; c++) begin
            s_gnt_i = (c == 5);
            #2; chk("bp_sreq", s_req_o, 1); chk("bp_saddr", s_addr_o, 32'h2000);
            chk("bp_swdata", s_wdata_o, 32'h1111); chk("bp_nognt", m_gnt_o, 2'b00);
            cyc();
        end
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
        #2; chk("bp_rvalid", m_rvalid_o, 2'b01); chk("bp_nognt2", m_gnt_o, 2'b00);
        cyc(); s_rvalid_i = 1'b0;
        #2; chk("bp_gnt1", m_gnt_o, 2'b10);
        cyc(); m_req_i = 2'b00; s_gnt_i = 1'b1;
        cyc(); s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
        #2; chk("bp_rvalid1", m_rvalid_o, 2'b10);
        cyc(); s_rvalid_i = 1'b0;

        // Timeout: slave takes the request but never answers.
        cyc(); m_req_i = 2'b10; m_addr_i[1] = 32'h3000;
        #2; chk("to_gnt", m_gnt_o, 2'b10);
        for (int c = 1; c <= T; c++) begin
            cyc(); m_req_i = 2'b00; s_gnt_i = (c == 1);
            #2; chk("to_quiet", m_rvalid_o, 2'b00);
        end
        cyc(); s_gnt_i = 1'b0;
        #2; chk("to_rvalid", m_rvalid_o, 2'b10); chk("to_err", m_err_o, 1);
        chk("to_rdata", m_rdata_o, 0);
        cyc(); s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        #2; chk("to_late", m_rvalid_o, 2'b00); chk("to_idle", busy_o, 0);
        cyc(); s_rvalid_i = 1'b0;

        // Reset while in WAIT.
        cyc(); m_req_i = 2'b01; m_addr_i[0] = 32'h4000;
        cyc(); m_req_i = 2'b00; s_gnt_i = 1'b1;
        cyc(); s_gnt_i = 1'b0;
        #2; chk("rw_busy", busy_o, 1);
        rst_i = 1'b1;
        #1; chk("rw_busy0", busy_o, 0); chk("rw_sreq0", s_req_o, 0);
        chk("rw_saddr0", s_addr_o, 0); chk("rw_rvalid0", m_rvalid_o, 0);
        cyc(); rst_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE;
        #2; chk("rw_stray", m_rvalid_o, 2'b00);
        cyc(); s_rvalid_i = 1'b0;

        // Tie: both masters hold requests across four transactions.
        cyc(); m_req_i = 2'b11; m_addr_i[0] = 32'h10; m_addr_i[1] = 32'h20;
        for (int t = 0; t < 4; t++) begin
            #2; chk("tie_gnt", m_gnt_o, exp_tie[t]);
            cyc(); s_gnt_i = 1'b1;
            cyc(); s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
            cyc(); s_rvalid_i = 1'b0;
            if (t == 3) m_req_i = 2'b00;
        end

        // Random traffic, including slow-slave stretches that force timeouts.
        for (int i = 0; i < 3000; i++) begin
            int gp;
            int rp;
            cyc();
            gp = (i < 1500) ? 50 : (i < 2400) ? 8 : 90;
            rp = (i < 1500) ? 40 : (i < 2400) ? 8 : 90;
            for (int k = 0; k < 2; k++) begin
                if (m_req_i[k]) begin
                    if (gnt_last[k]) begin
                        if ($urandom_range(1) == 1) new_fields(k);
                        else m_req_i[k] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    m_req_i[k] = 1'b1;
                    new_fields(k);
                end
            end
            s_gnt_i    = ($urandom_range(99) < gp);
            s_rvalid_i = ($urandom_range(99) < rp);
            s_rdata_i  = $urandom;
        end
        cyc();
        m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the data memory / IO bus. It shares the single LSU memory port between the pipeline's MEM stage (master 0) and a secondary requester (master 1), such as a program loader or debug port. It sequences one outstanding transaction at a time, routes the response to its owner, and terminates hung transactions with an error response after a timeout.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `TIMEOUT_CYC`, 64, cycles allowed in ISSUE+WAIT before an error response; must be ≥2
- `clk_i`  in  1  single clock; all state updates on the rising edge
- `rst_i`  in  1  reset, asynchronous and active-high
- `m_req_i`  in  2  per-master request; held stable until granted
- `m_we_i`  in  2  per-master write enable
- `m_addr_i`  in  2×ADDR_W  per-master address
- `m_wdata_i`  in  2×DATA_W  per-master write data
- `m_be_i`  in  2×DATA_W/8  per-master byte enables
- `m_gnt_o`  out  2  one-hot grant; request fields are captured on that edge
- `m_rvalid_o`  out  2  one-hot response valid, one cycle
- `m_rdata_o`  out  DATA_W  response data; valid only with `m_rvalid_o`
- `m_err_o`  out  1  response is a timeout error; qualified by `m_rvalid_o`
- `s_req_o`  out  1  slave request
- `s_we_o`, `s_addr_o`, `s_wdata_o`, `s_be_o`  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- `s_gnt_i`  in  1  slave accepts the request
- `s_rvalid_i`  in  1  slave response; the slave responds to both reads and writes
- `s_rdata_i`  in  DATA_W  slave read data
- `busy_o`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `m_req_i` is high, the winner k gets `m_gnt_o[k]=1` combinationally.
  - Its we/addr/wdata/be are latched, owner is set to k, the timeout counter is cleared, and the FSM goes to ISSUE.
  - No request: stay in IDLE.
- **ISSUE**
  - `s_req_o=1` with the latched fields.
  - `s_gnt_i=1`: go to WAIT.
  - Counter reaches `TIMEOUT_CYC`: `m_rvalid_o[owner]=1`, `m_err_o=1`, `m_rdata_o=0`, go to IDLE.
- **WAIT**
  - `s_req_o=0`.
  - `s_rvalid_i=1`: `m_rvalid_o[owner]=1` and `m_rdata_o=s_rdata_i`, both combinational, with `m_err_o=0`; go to IDLE.
  - Timeout: same error response as in ISSUE.
  - If `s_rvalid_i` and the timeout fire in the same cycle, the real response wins and `m_err_o=0`.
- **Timeout counter**
  - Width is `$clog2(TIMEOUT_CYC+1)`.
  - Increments in ISSUE and WAIT and saturates; it cannot wrap.
- **Stray responses**: `s_rvalid_i` in IDLE or ISSUE is ignored and produces no `m_rvalid_o`.
- **Grant timing**: only one grant per IDLE visit. A master whose request is still high after its response is re-arbitrated in the next IDLE.
- **Reset values**
  - All outputs are 0 and state is IDLE.
  - Counter is 0 and `last_owner` is 1, so master 0 wins the first tie.
  - Reset mid-transaction drops the in-flight access with no response.

## Timing
- Request seen in cycle 0 → `m_gnt_o` in cycle 0 → `s_req_o` in cycles 1..n until `s_gnt_i` → response passes through in the cycle of `s_rvalid_i` → IDLE in the following cycle.
- Best case: `s_gnt_i` in cycle 1 and `s_rvalid_i` in cycle 2 gives a 3-cycle issue-to-issue period per master.
- The only combinational paths are `m_req_i`→`m_gnt_o` (in IDLE) and `s_rvalid_i`/`s_rdata_i`→`m_rvalid_o`/`m_rdata_o`. All `s_*` request outputs are driven from flops.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin: on a tie in IDLE, the master ≠ `last_owner` wins.
  - `last_owner` updates on every grant.
- Undefined:
  - Fixed priority: master 0 always wins ties.
  - `last_owner` is unused and removed.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum `mem_arb_state_e` {IDLE, ISSUE, WAIT}
  - `MEM_ARB_NUM_M=2`
  - default `MEM_ARB_TIMEOUT=64`
- Sub-module `mem_arb_pick`: combinational winner select taking `m_req_i` and `last_owner` and producing a one-hot winner. The `MEM_ARB_RR_EN` switch lives inside it.
- The top module holds the FSM, the request capture registers, the timeout counter and response routing.

## Test plan
- **Single read**: m0 reads 0x1000; slave `s_gnt_i` in cycle 1 and `s_rvalid_i`, rdata 0xDEADBEEF, in cycle 2 → `m_gnt_o=01` in cycle 0, `s_addr_o=0x1000` in cycle 1, `m_rvalid_o=01` with `m_rdata_o=0xDEADBEEF` and `m_err_o=0` in cycle 2.
- **Tie with `MEM_ARB_RR_EN`**: both masters hold requests across 4 transactions → grant order m0, m1, m0, m1. Without the macro → m0 ×4 while m0 keeps requesting.
- **Slave backpressure**: `s_gnt_i` held low for 5 cycles → `s_req_o` and all `s_*` fields stay stable for 6 cycles; no second grant is issued.
- **Timeout**: `TIMEOUT_CYC=8`, slave never responds after grant → error response to the owner 8 cycles after entering ISSUE (`m_rvalid_o` one-hot, `m_err_o=1`, `m_rdata_o=0`); FSM back in IDLE. A late `s_rvalid_i` afterwards produces no output.
- **Reset mid-WAIT**: `rst_i` pulsed asynchronously while in WAIT → all outputs 0 immediately and `busy_o=0`. A subsequent `s_rvalid_i` is ignored. The next tie goes to m0.
- **Write**: m1 writes 0xA5 with `be=0001` to 0x7000 → `s_we_o=1`, `s_be_o=0001`, `s_wdata_o=0xA5`; on the slave response `m_rvalid_o=10` with `m_err_o=0`.
